// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the integer execution unit and the control path's
// ALU decoder: datapath width, 4-bit ALU operation codes, the execution FSM
// state encoding and the single-cycle result function.
package alu_pkg;

  localparam int XLEN = 32;

  // ALU control codes (codes 12..15 are unused and execute as ADD)
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLT   = 4'd5;
  localparam logic [3:0] ALU_SLTU  = 4'd6;
  localparam logic [3:0] ALU_SLL   = 4'd7;
  localparam logic [3:0] ALU_SRL   = 4'd8;
  localparam logic [3:0] ALU_SRA   = 4'd9;
  localparam logic [3:0] ALU_LUI   = 4'd10;
  localparam logic [3:0] ALU_AUIPC = 4'd11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_state_t;

  function automatic logic is_shift_op(input logic [3:0] code);
    return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
  endfunction

  // Result of every operation that completes in one cycle. Shift codes
  // return op_a: they only reach this path with a zero shift amount.
  function automatic logic [XLEN-1:0] alu_single_cycle(
    input logic [3:0]      code,
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b
  );
    logic lt_s;
    logic lt_u;
    logic [XLEN-1:0] res;
    lt_s = $signed(a) < $signed(b);
    lt_u = a < b;
    case (code)
      ALU_SUB:  res = a - b;
      ALU_AND:  res = a & b;
      ALU_OR:   res = a | b;
      ALU_XOR:  res = a ^ b;
      ALU_SLT:  res = {{(XLEN-1){1'b0}}, lt_s};
      ALU_SLTU: res = {{(XLEN-1){1'b0}}, lt_u};
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:  res = a;
      ALU_LUI:  res = b;
      default:  res = a + b;  // ADD, AUIPC and codes 12..15
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// alu_serial_shifter
// One-bit-per-cycle shifter driven by the alu_exec_unit FSM.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   load         capture data/shamt/direction for a new shift
//   step         advance one bit (ignored once the counter is 0)
//   data         value to shift (op_a)
//   shamt        shift amount, 0..31
//   right        1 = shift right, 0 = shift left
//   arith        1 = right shifts replicate bit XLEN-1
//   value        current shift register contents
//   next_value   contents after one more step
//   busy         counter is non-zero
//   last         exactly one step remains
module alu_serial_shifter
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] data,
  input  logic [4:0]      shamt,
  input  logic            right,
  input  logic            arith,
  output logic [XLEN-1:0] value,
  output logic [XLEN-1:0] next_value,
  output logic            busy,
  output logic            last
);

  logic [XLEN-1:0] sh_q;
  logic [4:0]      cnt_q;
  logic            right_q;
  logic            arith_q;

  // Fill bit for right shifts: sign bit for SRA, zero for SRL.
  always_comb begin
    next_value = sh_q;
    if (right_q) begin
      next_value = {arith_q & sh_q[XLEN-1], sh_q[XLEN-1:1]};
    end else begin
      next_value = {sh_q[XLEN-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_q    <= '0;
      cnt_q   <= '0;
      right_q <= 1'b0;
      arith_q <= 1'b0;
    end else if (load) begin
      sh_q    <= data;
      cnt_q   <= shamt;
      right_q <= right;
      arith_q <= arith;
    end else if (step && (cnt_q != 5'd0)) begin
      sh_q  <= next_value;
      cnt_q <= cnt_q - 5'd1;
    end
  end

  assign value = sh_q;
  assign busy  = (cnt_q != 5'd0);
  assign last  = (cnt_q == 5'd1);

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit
// Multi-cycle integer execution unit. Single-cycle ops finish on the accept
// edge; SLL/SRL/SRA with a non-zero amount run through a serial shifter at
// one bit per cycle.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. The input side is ready only in IDLE (and out of reset); the
// output side is valid only in DONE, with result/flags held stable until the
// transfer and retained afterwards until the next completion.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   in_valid        request valid
//   in_ready        unit can accept a request
//   alu_control     4-bit ALU operation code (alu_pkg ALU_*)
//   op_a, op_b      operands; op_b[4:0] is the shift amount
//   out_valid       result valid
//   out_ready       consumer accepts the result
//   result          operation result
//   zero            result == 0
//   lt, ltu         signed / unsigned op_a < op_b of the captured operands
//   fsm_state       current FSM state (alu_state_t encoding) for observation
module alu_exec_unit
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_control,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            lt,
  output logic            ltu,
  output logic [1:0]      fsm_state
);

  alu_state_t state_q;
  alu_state_t next_state;

  logic            accept;
  logic            start_shift;
  logic            capture_single;
  logic            capture_shift;
  logic            shift_step;

  logic [XLEN-1:0] single_res;
  logic [XLEN-1:0] shift_res;
  logic            lt_in;
  logic            ltu_in;

  // Flags of the operands captured for an in-flight shift, published on DONE.
  logic            lt_cap;
  logic            ltu_cap;

  logic [XLEN-1:0] result_q;
  logic            zero_q;
  logic            lt_q;
  logic            ltu_q;

  logic [XLEN-1:0] sh_value;
  logic [XLEN-1:0] sh_next;
  logic            sh_busy;
  logic            sh_last;

  assign in_ready   = (state_q == IDLE) && rst_n;
  assign accept     = in_valid && in_ready;
  assign single_res = alu_single_cycle(alu_control, op_a, op_b);
  assign lt_in      = $signed(op_a) < $signed(op_b);
  assign ltu_in     = op_a < op_b;

  // On the final step the register has not yet taken its last shift, so the
  // published result is the one-step-ahead value.
  assign shift_res  = sh_busy ? sh_next : sh_value;

  alu_serial_shifter u_shifter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (start_shift),
    .step       (shift_step),
    .data       (op_a),
    .shamt      (op_b[4:0]),
    .right      (alu_control != ALU_SLL),
    .arith      (alu_control == ALU_SRA),
    .value      (sh_value),
    .next_value (sh_next),
    .busy       (sh_busy),
    .last       (sh_last)
  );

  always_comb begin
    next_state     = state_q;
    start_shift    = 1'b0;
    capture_single = 1'b0;
    capture_shift  = 1'b0;
    shift_step     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_shift_op(alu_control) && (op_b[4:0] != 5'd0)) begin
            next_state  = SHIFT;
            start_shift = 1'b1;
          end else begin
            next_state     = DONE;
            capture_single = 1'b1;
          end
        end
      end
      SHIFT: begin
        shift_step = 1'b1;
        // Leave on the edge that performs the last step (or immediately if
        // the counter is somehow already empty).
        if (sh_last || !sh_busy) begin
          next_state    = DONE;
          capture_shift = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      lt_q     <= 1'b0;
      ltu_q    <= 1'b0;
      lt_cap   <= 1'b0;
      ltu_cap  <= 1'b0;
    end else begin
      state_q <= next_state;
      if (start_shift) begin
        lt_cap  <= lt_in;
        ltu_cap <= ltu_in;
      end
      if (capture_single) begin
        result_q <= single_res;
        zero_q   <= (single_res == '0);
        lt_q     <= lt_in;
        ltu_q    <= ltu_in;
      end else if (capture_shift) begin
        result_q <= shift_res;
        zero_q   <= (shift_res == '0);
        lt_q     <= lt_cap;
        ltu_q    <= ltu_cap;
      end
    end
  end

  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign lt        = lt_q;
  assign ltu       = ltu_q;
  assign fsm_state = state_q;

endmodule
